// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared constants for the seqgen transmitter and seqcheck detector.
// Holds the sync pattern, its length and the generator state encoding.
package seqgen_pkg;

  localparam int SYNC_LEN = 6;
  localparam logic [SYNC_LEN-1:0] SYNC_PAT = 6'b101011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seqgen_piso.sv
// seqgen_piso: loadable MSB-first parallel-in/serial-out shift register.
// nxt is the bit that becomes the head after the next shift, so the owner can
// register it into its output flop on the same edge that performs the shift.
module seqgen_piso #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             nxt
);

  logic [WIDTH-1:0] shreg;

  // Load the whole frame word on accept, otherwise shift toward the MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg << 1;
    end
  end

  assign nxt = shreg[WIDTH-2];

endmodule

// File: rtl/seqgen.sv
// seqgen: serial frame generator (transmit end of the seqcheck link).
// Frame = sync pattern 101011, payload MSB-first, optional parity, GAP zeros.
// Optional build macro: SEQGEN_PARITY_EN adds one even-parity bit after DATA.
module seqgen
  import seqgen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              out,
  output logic              busy,
  output logic              sof
);

  localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP) + 1);
  localparam int PW    = SYNC_LEN + DATA_W;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] SOF_CNT   = CNT_W'(SYNC_LEN - 2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             piso_next;

`ifdef SEQGEN_PARITY_EN
  logic             par_bit;
`endif

  assign ready  = (state == ST_IDLE);
  assign accept = valid && ready;

  seqgen_piso #(
    .WIDTH(PW)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(state != ST_IDLE),
    .din  ({SYNC_PAT, data}),
    .nxt  (piso_next)
  );

  // Frame sequencer: out/sof/busy are registered one bit ahead of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
      sof   <= 1'b0;
`ifdef SEQGEN_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      sof <= 1'b0;
      case (state)
        ST_IDLE: begin
          out <= 1'b0;
          if (accept) begin
            state <= ST_SYNC;
            cnt   <= '0;
            out   <= SYNC_PAT[SYNC_LEN-1];
            busy  <= 1'b1;
`ifdef SEQGEN_PARITY_EN
            par_bit <= ^data;
`endif
          end
        end
        ST_SYNC: begin
          out <= piso_next;
          sof <= (cnt == SOF_CNT);
          if (cnt == SYNC_LAST) begin
            state <= ST_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == DATA_LAST) begin
            cnt <= '0;
`ifdef SEQGEN_PARITY_EN
            state <= ST_PAR;
            out   <= par_bit;
`else
            out <= 1'b0;
            if (GAP > 0) begin
              state <= ST_GAP;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
`endif
          end else begin
            out <= piso_next;
            cnt <= cnt + 1'b1;
          end
        end
        ST_PAR: begin
          out <= 1'b0;
          cnt <= '0;
          if (GAP > 0) begin
            state <= ST_GAP;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_GAP: begin
          out <= 1'b0;
          if (cnt == GAP_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
